// File: rtl/bitwise_unit_pipe.sv
// -----------------------------------------------------------------------------
// bitwise_unit_pipe
//   Registered, handshaked bitwise logic unit. Each accepted beat computes one
//   of eight bitwise operations on a and either b or the accumulator (chain
//   mode). The result is pushed into a DEPTH-entry output FIFO that absorbs
//   downstream backpressure. zr/ng status flags describe the FIFO head.
//
// Parameters
//   WIDTH : operand/result width in bits (>=1)
//   DEPTH : output FIFO entries (power of two, >=2)
//
// Ports
//   clk       : system clock, all state on the rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : operand beat presented
//   in_ready  : unit can accept a beat this cycle (combinational on out_ready)
//   a, b      : operands (b ignored when chain=1)
//   op        : operation select
//   chain     : use the accumulator as operand b
//   out_valid : FIFO head valid
//   out_ready : consumer takes the head this cycle
//   out       : result at FIFO head (0 when empty)
//   zr, ng    : head == 0, head MSB
//   count     : current FIFO occupancy
// -----------------------------------------------------------------------------
module bitwise_unit_pipe #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         a,
   input  logic [WIDTH-1:0]         b,
   input  logic [2:0]               op,
   input  logic                     chain,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out,
   output logic                     zr,
   output logic                     ng,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_acc;
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;

   logic             w_push;
   logic             w_pop;
   logic [WIDTH-1:0] w_bo;
   logic [WIDTH-1:0] w_res;
   logic [WIDTH-1:0] w_head;

   function automatic logic [WIDTH-1:0] f_logic(input logic [2:0]       sel,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] r;
      r = '0;
      unique case (sel)
         3'b000:  r = x & y;
         3'b001:  r = x | y;
         3'b010:  r = x ^ y;
         3'b011:  r = ~(x & y);
         3'b100:  r = ~(x | y);
         3'b101:  r = ~(x ^ y);
         3'b110:  r = ~x;
         default: r = x;
      endcase
      return r;
   endfunction

   assign w_bo  = chain ? r_acc : b;
   assign w_res = f_logic(op, a, w_bo);

   // A full FIFO can still accept when the head leaves on the same edge.
   assign out_valid = (r_count != '0);
   assign in_ready  = (r_count < FULL_C) || out_ready;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   // Head is masked to zero when empty so stale storage never leaks out.
   assign w_head = r_mem[r_rptr];
   assign out    = out_valid ? w_head : '0;
   assign zr     = (out == '0);
   assign ng     = out[WIDTH-1];
   assign count  = r_count;

   // Control state: pointers, occupancy, accumulator
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_acc   <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
            r_acc  <= w_res;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage: data only, written at the tail on accept
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= w_res;
      end
   end

endmodule
